wb_initiator: RTL
=================

Name: wb_initiator

Overview:
- Wishbone B4 pipelined bus initiator. Converts single-beat read/write commands from a client into one Wishbone classic-pipelined transaction each, then returns a response.
- Clients are the SPI command decoder and the video fetch logic. Targets are peripherals such as the external SRAM controller, which asserts stall while busy and pulses ack once when done.
- Exactly one transaction is outstanding at a time.

Parameters:
- DATA_WIDTH, 8, width of wb_data_i/o, cmd_data_i, rsp_data_o.
- ADDR_WIDTH, 17, width of wb_addr_o and cmd_addr_i.
- TIMEOUT_CYCLES, 64, watchdog limit in clocks. Used only with WB_TIMEOUT_EN. Must be ≥2.

Ports:
- wb_clock_i  in  1  single clock; all logic on its rising edge
- wb_reset_i  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  client command present
- cmd_ready_o  out  1  initiator accepts command this cycle
- cmd_we_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_data_i  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  client consumes response
- rsp_data_o  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err_o  out  1  transaction timed out
- wb_cycle_o  out  1  Wishbone CYC
- wb_strobe_o  out  1  Wishbone STB
- wb_we_o  out  1  Wishbone WE
- wb_addr_o  out  ADDR_WIDTH  Wishbone ADR
- wb_data_o  out  DATA_WIDTH  Wishbone DAT (initiator to target)
- wb_data_i  in  DATA_WIDTH  Wishbone DAT (target to initiator)
- wb_stall_i  in  1  target cannot accept the strobe
- wb_ack_i  in  1  target completion

Behaviour:
- Reset (wb_reset_i low, asynchronous): state=IDLE.
  - All outputs 0: cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, wb_cycle_o, wb_strobe_o, wb_we_o, wb_addr_o, wb_data_o.
  - Watchdog counter=0.
  - Reset asserted mid-transaction drops cyc/stb immediately, with no response.
- All outputs are registered.
- State machine:
  - IDLE:
    - cmd_ready_o=1.
    - On cmd_valid_i: latch cmd_we_i/addr/data into wb_we_o/wb_addr_o/wb_data_o, set wb_cycle_o=1 and wb_strobe_o=1, cmd_ready_o=0, then go to STROBE.
    - First bus cycle is the clock after acceptance.
  - STROBE:
    - cyc=1, stb=1; address, data and we held stable.
    - Request is accepted on the edge where stb=1 and wb_stall_i=0. On acceptance, stb←0 and the machine goes to WAIT_ACK.
    - If wb_ack_i is also high on that edge, it counts as completion and the machine goes directly to RESPOND.
    - wb_stall_i may be held indefinitely; stb stays high throughout.
  - WAIT_ACK:
    - cyc=1, stb=0.
    - On wb_ack_i: cyc←0 and we←0. For reads, rsp_data_o←wb_data_i; for writes, rsp_data_o←0. rsp_err_o←0, rsp_valid_o←1, then go to RESPOND.
  - RESPOND:
    - rsp_valid_o=1 until the edge where rsp_ready_i=1. Then rsp_valid_o←0, cmd_ready_o←1, go to IDLE.
    - rsp_data_o and rsp_err_o are held stable while valid.
- No back-to-back overlap. Minimum command-to-command spacing is 4 clocks (IDLE, STROBE, WAIT_ACK, RESPOND), given zero stall, ack 1 clock after acceptance, and rsp_ready_i already high.
- wb_ack_i outside STROBE/WAIT_ACK is ignored (no state change, no response).
- wb_data_i is sampled only on the completing ack edge of a read.
- Addresses and data pass through unchanged; there is no arithmetic on them.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on command acceptance and increments every clock in STROBE and WAIT_ACK.
  - When it reaches TIMEOUT_CYCLES-1 without ack: cyc←0, stb←0, rsp_err_o←1, rsp_data_o←0, rsp_valid_o←1, go to RESPOND.
  - A late ack arriving afterwards is ignored.
  - If ack and timeout occur on the same edge, the ack wins and rsp_err_o=0.
- Undefined:
  - No counter logic is synthesized; rsp_err_o is tied to 0.
  - The initiator waits forever for ack.

Test Plan:
- Write, no stall. Setup: cmd we=1, addr=17'h1_2345, data=8'hA5; target acks 1 clock after acceptance. Required: exactly one stb-high cycle with we=1, adr=1_2345, dat=A5; then rsp_valid=1, rsp_data=00, rsp_err=0; cyc low after ack.
- Read with stall. Setup: cmd we=0, addr=17'h0_0400; target stalls 6 clocks, then acks 2 clocks later with data 8'h3C. Required: stb held high for 7 clocks with adr stable; rsp_data=3C, rsp_err=0.
- Response backpressure. Setup: read completes while rsp_ready_i=0 for 5 clocks, and a new cmd_valid_i is pending. Required: rsp_valid and data held; cmd_ready_o=0 throughout; next command is accepted only after the rsp_ready handshake.
- Ack on the acceptance edge. Setup: target drives stall=0 and ack=1 together on the first strobe cycle. Required: direct STROBE→RESPOND; cyc high for exactly 1 clock.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=16). Setup: target never acks. Required: cyc drops after 16 clocks; rsp_err=1, rsp_data=00; an ack injected afterwards is ignored. Also: ack on exactly the 16th clock gives rsp_err=0.
- Async reset. Setup: assert wb_reset_i low mid-WAIT_ACK between clock edges. Required: cyc, stb and rsp_valid go to 0 immediately. After release, cmd_ready_o=1 and a fresh read completes normally.

Source files
------------

// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined initiator: turns one client command into one single-beat bus transaction.
// Optional watchdog abort is compiled in when WB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module wb_initiator #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 17,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  wb_cycle_o,
    output logic                  wb_strobe_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STROBE   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RESPOND  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_ok, done_to;
    logic                  timeout_hit;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;

    assign timeout_hit = (cnt_q == CNT_LIMIT);
    assign rsp_err_o   = rsp_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);
    assign timeout_hit        = 1'b0;
    assign rsp_err_o          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        done_ok     = 1'b0;
        done_to     = 1'b0;
`ifdef WB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d        = cmd_we_i;
                    addr_d      = cmd_addr_i;
                    data_d      = cmd_data_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_STROBE;
`ifdef WB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_STROBE: begin
`ifdef WB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // An ack on the accepting edge completes the transfer; ack beats the watchdog.
                if (!wb_stall_i && wb_ack_i) begin
                    done_ok = 1'b1;
                end else if (timeout_hit) begin
                    done_to = 1'b1;
                end else if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
`ifdef WB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (wb_ack_i) begin
                    done_ok = 1'b1;
                end else if (timeout_hit) begin
                    done_to = 1'b1;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done_ok || done_to) begin
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            we_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = (done_to || we_q) ? '0 : wb_data_i;
            state_d     = ST_RESPOND;
`ifdef WB_TIMEOUT_EN
            rsp_err_d   = done_to;
`endif
        end
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_i) begin
        if (!wb_reset_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign wb_cycle_o  = cyc_q;
    assign wb_strobe_o = stb_q;
    assign wb_we_o     = we_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = data_q;

endmodule
